// File: rtl/piezo_tone_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : piezo_tone_rx                                                |
// | Description : Piezo square-wave receiver. Measures the period between      |
// |               rising edges, classifies it as G6/C7/E7/G7, confirms notes   |
// |               after a run of matching periods, and recognises the          |
// |               low-battery (G6-C7-E7, silence) and fanfare                  |
// |               (G6-C7-E7-G7-E7-G7) melodies.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module piezo_tone_rx #(
  parameter int FAST_SIM     = 1,
  parameter int NOTE_CONFIRM = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       piezo_in,
  output logic [2:0] note,
  output logic       note_vld,
  output logic       tone_active,
  output logic       batt_low_det,
  output logic       fanfare_det
);

  // Period counter increment; the accelerated driver runs 16x faster.
  localparam logic [15:0] C_STEP    = (FAST_SIM != 0) ? 16'd16 : 16'd1;
  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;
  localparam logic [3:0]  C_CONFIRM = 4'(NOTE_CONFIRM);

  // Period class codes; 0 doubles as "unknown" for the tracker and "none" for note.
  localparam logic [2:0] C_UNK = 3'd0;
  localparam logic [2:0] C_G6  = 3'd1;
  localparam logic [2:0] C_C7  = 3'd2;
  localparam logic [2:0] C_E7  = 3'd3;
  localparam logic [2:0] C_G7  = 3'd4;

  // Inclusive band limits on the measured period value.
  localparam logic [15:0] C_G6_LO = 16'd30000;
  localparam logic [15:0] C_G6_HI = 16'd33800;
  localparam logic [15:0] C_C7_LO = 16'd22500;
  localparam logic [15:0] C_C7_HI = 16'd25300;
  localparam logic [15:0] C_E7_LO = 16'd17900;
  localparam logic [15:0] C_E7_HI = 16'd20100;
  localparam logic [15:0] C_G7_LO = 16'd15000;
  localparam logic [15:0] C_G7_HI = 16'd16900;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_G6   = 3'd1,
    S_C7   = 3'd2,
    S_E7   = 3'd3,
    S_G7   = 3'd4,
    S_E7B  = 3'd5
  } seq_state_t;

  // Input path: [0],[1] synchronise, [2] is the edge-detect history bit.
  logic [2:0]  sync_q, sync_d;
  logic        rise_q, rise_d;

  // Period measurement and note tracking.
  logic [15:0] cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic [3:0]  run_q, run_d;
  logic [2:0]  cls_q, cls_d;
  logic [2:0]  last_note_q, last_note_d;

  // Registered outputs.
  logic [2:0]  note_q, note_d;
  logic        note_vld_q, note_vld_d;
  logic        tone_active_q, tone_active_d;
  logic        batt_low_q, batt_low_d;
  logic        fanfare_q, fanfare_d;

  seq_state_t  state_q, state_d;

  // Internal events handed from the tracker to the melody FSM.
  logic [16:0] cnt_sum;
  logic [15:0] cnt_inc;
  logic [2:0]  cls_now;
  logic        sil_evt;
  logic        note_evt;

  function automatic logic [2:0] classify(input logic [15:0] p);
    logic [2:0] c;
    c = C_UNK;
    if      (p >= C_G6_LO && p <= C_G6_HI) c = C_G6;
    else if (p >= C_C7_LO && p <= C_C7_HI) c = C_C7;
    else if (p >= C_E7_LO && p <= C_E7_HI) c = C_E7;
    else if (p >= C_G7_LO && p <= C_G7_HI) c = C_G7;
    return c;
  endfunction

  // Synchroniser shift and rising-edge detection, registered once more so the
  // tracker works from a clean single-cycle strobe.
  always_comb begin
    sync_d = {sync_q[1:0], piezo_in};
    rise_d = sync_q[1] & ~sync_q[2];
  end

  // Period measurement, run tracking, note confirmation and silence detection.
  always_comb begin
    cnt_sum       = {1'b0, cnt_q} + {1'b0, C_STEP};
    cnt_inc       = cnt_sum[16] ? C_CNT_MAX : cnt_sum[15:0];
    cls_now       = classify(cnt_q);

    cnt_d         = cnt_inc;
    armed_d       = armed_q;
    run_d         = run_q;
    cls_d         = cls_q;
    last_note_d   = last_note_q;
    note_d        = note_q;
    tone_active_d = tone_active_q;
    note_evt      = 1'b0;
    sil_evt       = 1'b0;

    if (rise_q) begin
      // A rise always restarts the measurement, even on the saturation cycle.
      cnt_d = '0;
      if (!armed_q) begin
        armed_d = 1'b1;
      end else if (cls_now == C_UNK) begin
        // Out-of-band periods (note boundaries, glitches) break the run quietly.
        run_d = '0;
        cls_d = C_UNK;
      end else begin
        tone_active_d = 1'b1;
        cls_d         = cls_now;
        if (cls_now == cls_q) begin
          run_d = (run_q < C_CONFIRM) ? run_q + 4'd1 : C_CONFIRM;
        end else begin
          run_d = 4'd1;
        end
        // Only a change of note is reported, so a run resumed after a glitch
        // stays silent.
        if (run_d == C_CONFIRM && cls_now != last_note_q) begin
          note_d      = cls_now;
          last_note_d = cls_now;
          note_evt    = 1'b1;
        end
      end
    end else if (cnt_inc == C_CNT_MAX && cnt_q != C_CNT_MAX) begin
      // First cycle of saturation: one silence event, the held state is quiet.
      sil_evt       = 1'b1;
      armed_d       = 1'b0;
      run_d         = '0;
      cls_d         = C_UNK;
      last_note_d   = C_UNK;
      note_d        = C_UNK;
      tone_active_d = 1'b0;
    end

    note_vld_d = note_evt;
  end

  // Melody recogniser next-state and detector pulses.
  always_comb begin
    state_d    = state_q;
    batt_low_d = 1'b0;
    fanfare_d  = 1'b0;

    if (sil_evt) begin
      batt_low_d = (state_q == S_E7);
      state_d    = S_IDLE;
    end else if (note_evt) begin
      // Out-of-sequence note: a G6 can always start a new melody.
      state_d = (cls_now == C_G6) ? S_G6 : S_IDLE;
      case (state_q)
        S_G6:    if (cls_now == C_C7) state_d = S_C7;
        S_C7:    if (cls_now == C_E7) state_d = S_E7;
        S_E7:    if (cls_now == C_G7) state_d = S_G7;
        S_G7:    if (cls_now == C_E7) state_d = S_E7B;
        S_E7B: begin
          if (cls_now == C_G7) begin
            state_d   = S_IDLE;
            fanfare_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '0;
      rise_q        <= 1'b0;
      cnt_q         <= '0;
      armed_q       <= 1'b0;
      run_q         <= '0;
      cls_q         <= C_UNK;
      last_note_q   <= C_UNK;
      note_q        <= C_UNK;
      note_vld_q    <= 1'b0;
      tone_active_q <= 1'b0;
      batt_low_q    <= 1'b0;
      fanfare_q     <= 1'b0;
      state_q       <= S_IDLE;
    end else begin
      sync_q        <= sync_d;
      rise_q        <= rise_d;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      run_q         <= run_d;
      cls_q         <= cls_d;
      last_note_q   <= last_note_d;
      note_q        <= note_d;
      note_vld_q    <= note_vld_d;
      tone_active_q <= tone_active_d;
      batt_low_q    <= batt_low_d;
      fanfare_q     <= fanfare_d;
      state_q       <= state_d;
    end
  end

  assign note         = note_q;
  assign note_vld     = note_vld_q;
  assign tone_active  = tone_active_q;
  assign batt_low_det = batt_low_q;
  assign fanfare_det  = fanfare_q;

endmodule
`default_nettype wire
